custom_xif_scheduler: RTL and testbench

CUSTOM_XIF_SCHEDULER -- requirements
Module: custom_xif_scheduler

---
 rtl/custom_xif_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_custom_xif_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_xif_scheduler.sv
// Issue/commit/result scheduler for one custom opcode: a small FIFO of outstanding
// instructions whose head is walked through commit, execution and result hand-off.
module custom_xif_scheduler #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ID_W   = 4,
  parameter logic [6:0]  OPCODE = 7'h0B
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [31:0]     issue_rs0_i,
  input  logic [31:0]     issue_rs1_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            ex_start_o,
  output logic [31:0]     ex_rs0_o,
  output logic [31:0]     ex_rs1_o,
  input  logic            ex_done_i,
  input  logic [31:0]     ex_result_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic [31:0]     result_data_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    EXEC        = 2'd2,
    RESULT      = 2'd3
  } state_e;

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] cmt_q;
  logic [DEPTH-1:0] kill_q;
  logic [ID_W-1:0]  id_q  [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      rs0_q [DEPTH];
  logic [31:0]      rs1_q [DEPTH];

  logic             ex_start_q;
  logic [31:0]      ex_rs0_q;
  logic [31:0]      ex_rs1_q;
  logic             res_valid_q;
  logic [ID_W-1:0]  res_id_q;
  logic [4:0]       res_rd_q;
  logic [31:0]      res_data_q;

  logic             accept_s;
  logic             enq_s;
  logic             pop_s;
  logic             head_busy_s;
  logic             enq_hit_s;
  logic [DEPTH-1:0] commit_hit_s;
  logic             unused_s;

  assign accept_s          = issue_valid_i && (issue_instr_i[6:0] == OPCODE);
  assign issue_accept_o    = accept_s;
  assign issue_writeback_o = accept_s;
  assign issue_ready_o     = (count_q < DEPTH_C);
  assign enq_s             = accept_s && issue_ready_o;
  assign head_busy_s       = (state_q == EXEC) || (state_q == RESULT);
  assign enq_hit_s         = commit_valid_i && (commit_id_i == issue_id_i);
  assign unused_s          = ^issue_instr_i[31:12];

  assign ex_start_o     = ex_start_q;
  assign ex_rs0_o       = ex_rs0_q;
  assign ex_rs1_o       = ex_rs1_q;
  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_data_o  = res_data_q;

  // Head pop, per-entry commit match (head frozen once it executes) and next occupancy
  always_comb begin
    pop_s        = 1'b0;
    commit_hit_s = '0;
    case (state_q)
      WAIT_COMMIT: pop_s = kill_q[rd_ptr_q];
      RESULT:      pop_s = result_ready_i;
      default:     pop_s = 1'b0;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit_s[i] = commit_valid_i && vld_q[i] && (id_q[i] == commit_id_i) &&
                        !(head_busy_s && (rd_ptr_q == PTR_W'(i)));
    end
    if (enq_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_s && !enq_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Outstanding-instruction FIFO with commit/kill marking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      cmt_q    <= '0;
      kill_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]  <= '0;
        rd_q[i]  <= 5'd0;
        rs0_q[i] <= 32'd0;
        rs1_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit_s[i]) begin
          cmt_q[i]  <= 1'b1;
          kill_q[i] <= commit_kill_i;
        end
      end
      if (pop_s) begin
        vld_q[rd_ptr_q]  <= 1'b0;
        cmt_q[rd_ptr_q]  <= 1'b0;
        kill_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PTR_W'(1);
      end
      // A commit racing the enqueue of its own ID lands on the fresh entry
      if (enq_s) begin
        vld_q[wr_ptr_q]  <= 1'b1;
        cmt_q[wr_ptr_q]  <= enq_hit_s;
        kill_q[wr_ptr_q] <= enq_hit_s && commit_kill_i;
        id_q[wr_ptr_q]   <= issue_id_i;
        rd_q[wr_ptr_q]   <= issue_instr_i[11:7];
        rs0_q[wr_ptr_q]  <= issue_rs0_i;
        rs1_q[wr_ptr_q]  <= issue_rs1_i;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Head-entry control FSM with registered datapath and result outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ex_start_q  <= 1'b0;
      ex_rs0_q    <= 32'd0;
      ex_rs1_q    <= 32'd0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rd_q    <= 5'd0;
      res_data_q  <= 32'd0;
    end else begin
      ex_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q <= WAIT_COMMIT;
          end
        end
        WAIT_COMMIT: begin
          if (cmt_q[rd_ptr_q] && !kill_q[rd_ptr_q]) begin
            ex_start_q <= 1'b1;
            ex_rs0_q   <= rs0_q[rd_ptr_q];
            ex_rs1_q   <= rs1_q[rd_ptr_q];
            state_q    <= EXEC;
          end else if (kill_q[rd_ptr_q]) begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          if (ex_done_i) begin
            res_valid_q <= 1'b1;
            res_id_q    <= id_q[rd_ptr_q];
            res_rd_q    <= rd_q[rd_ptr_q];
            res_data_q  <= ex_result_i;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (result_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_xif_scheduler.sv
// Bench for custom_xif_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_custom_xif_scheduler;
  localparam int DEPTH = 2;
  localparam int ID_W  = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            issue_valid_i = 1'b0;
  logic            issue_ready_o;
  logic [31:0]     issue_instr_i = 32'd0;
  logic [ID_W-1:0] issue_id_i = '0;
  logic [31:0]     issue_rs0_i = 32'd0;
  logic [31:0]     issue_rs1_i = 32'd0;
  logic            issue_accept_o;
  logic            issue_writeback_o;
  logic            commit_valid_i = 1'b0;
  logic [ID_W-1:0] commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            ex_start_o;
  logic [31:0]     ex_rs0_o;
  logic [31:0]     ex_rs1_o;
  logic            ex_done_i = 1'b0;
  logic [31:0]     ex_result_i = 32'd0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b0;
  logic [ID_W-1:0] result_id_o;
  logic [4:0]      result_rd_o;
  logic [31:0]     result_data_o;

  always #5 clk_i = ~clk_i;

  custom_xif_scheduler #(.DEPTH(DEPTH), .ID_W(ID_W), .OPCODE(7'h0B)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .ex_start_o(ex_start_o), .ex_rs0_o(ex_rs0_o), .ex_rs1_o(ex_rs1_o),
    .ex_done_i(ex_done_i), .ex_result_i(ex_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic [31:0]     rs0;
    logic [31:0]     rs1;
    bit              cmt;
    bit              kil;
  } ent_t;

  ent_t            mq[$];
  int              mode = 0;   // 0 idle, 1 awaiting commit, 2 executing, 3 presenting result
  bit              m_start = 1'b0;
  bit              m_rv = 1'b0;
  logic [31:0]     m_rs0 = 32'd0, m_rs1 = 32'd0, m_data = 32'd0;
  logic [ID_W-1:0] m_id = '0;
  logic [4:0]      m_rd = 5'd0;
  bit              cmp_en = 1'b0;

  task automatic model_step();
    ent_t e;
    bit   pop;
    bit   enq;
    int   nmode;
    if (!rst_ni) begin
      mq.delete();
      mode = 0; m_start = 1'b0; m_rv = 1'b0;
      m_rs0 = 32'd0; m_rs1 = 32'd0; m_data = 32'd0; m_id = '0; m_rd = 5'd0;
    end else begin
      pop = 1'b0;
      nmode = mode;
      m_start = 1'b0;
      enq = issue_valid_i && (mq.size() < DEPTH) && (issue_instr_i[6:0] == 7'h0B);
      case (mode)
        0: if (mq.size() > 0) nmode = 1;
        1: begin
          if (mq[0].cmt && !mq[0].kil) begin
            m_start = 1'b1; m_rs0 = mq[0].rs0; m_rs1 = mq[0].rs1; nmode = 2;
          end else if (mq[0].kil) begin
            pop = 1'b1; nmode = 0;
          end
        end
        2: if (ex_done_i) begin
          m_rv = 1'b1; m_id = mq[0].id; m_rd = mq[0].rd; m_data = ex_result_i; nmode = 3;
        end
        3: if (result_ready_i) begin
          m_rv = 1'b0; pop = 1'b1; nmode = 0;
        end
        default: nmode = 0;
      endcase
      if (commit_valid_i) begin
        foreach (mq[j]) begin
          if (mq[j].id == commit_id_i && !(j == 0 && (mode == 2 || mode == 3))) begin
            mq[j].cmt = 1'b1;
            mq[j].kil = commit_kill_i;
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (enq) begin
        e.id = issue_id_i; e.rd = issue_instr_i[11:7];
        e.rs0 = issue_rs0_i; e.rs1 = issue_rs1_i;
        e.cmt = commit_valid_i && (commit_id_i == issue_id_i);
        e.kil = e.cmt && commit_kill_i;
        mq.push_back(e);
      end
      mode = nmode;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && cmp_en) begin
        chk("issue_ready", 32'(issue_ready_o), 32'(mq.size() < DEPTH));
        chk("accept", 32'(issue_accept_o),
            32'(issue_valid_i && (issue_instr_i[6:0] == 7'h0B)));
        chk("writeback", 32'(issue_writeback_o),
            32'(issue_valid_i && (issue_instr_i[6:0] == 7'h0B)));
        chk("ex_start", 32'(ex_start_o), 32'(m_start));
        chk("result_valid", 32'(result_valid_o), 32'(m_rv));
        if (m_rv) begin
          chk("result_id", 32'(result_id_o), 32'(m_id));
          chk("result_rd", 32'(result_rd_o), 32'(m_rd));
          chk("result_data", result_data_o, m_data);
        end
        if (mode == 2) begin
          chk("ex_rs0", ex_rs0_o, m_rs0);
          chk("ex_rs1", ex_rs1_o, m_rs1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int          start_cnt = 0;
  bit          rand_dp = 1'b0;
  int          done_lat = 2;
  logic [31:0] done_val = 32'd0;
  bit          dp_busy = 1'b0;
  int          dp_cnt = 0;

  task automatic step();
    @(posedge clk_i);
    #2;
    if (ex_start_o) start_cnt++;
    ex_done_i = 1'b0;
    if (ex_start_o) begin
      dp_busy = 1'b1;
      dp_cnt = rand_dp ? int'($urandom_range(3, 1)) : done_lat;
    end else if (dp_busy) begin
      dp_cnt--;
      if (dp_cnt == 0) begin
        ex_done_i = 1'b1;
        ex_result_i = rand_dp ? $urandom : done_val;
        dp_busy = 1'b0;
      end
    end
    issue_valid_i = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i = 1'b0;
  endtask

  task automatic set_issue(input logic [ID_W-1:0] id, input logic [4:0] rd, input logic [6:0] op,
                           input logic [31:0] rs0, input logic [31:0] rs1);
    logic [31:0] w;
    w = $urandom;
    w[11:7] = rd;
    w[6:0] = op;
    issue_valid_i = 1'b1;
    issue_instr_i = w;
    issue_id_i = id;
    issue_rs0_i = rs0;
    issue_rs1_i = rs1;
  endtask

  task automatic set_commit(input logic [ID_W-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i = id;
    commit_kill_i = kill;
  endtask

  task automatic wait_result(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (result_valid_o) break;
      step();
    end
    chk("result_arrives", 32'(result_valid_o), 32'd1);
  endtask

  task automatic take_result();
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_start", 32'(ex_start_o), 32'd0);
    chk("rst_rvalid", 32'(result_valid_o), 32'd0);
    chk("rst_rs0", ex_rs0_o, 32'd0);
    chk("rst_rdata", result_data_o, 32'd0);
    rst_ni = 1'b1;
    cmp_en = 1'b1;
    step();

    // Basic execute: id 3, rd 5, result 0x4 two cycles after start
    start_cnt = 0;
    done_lat = 2; done_val = 32'h4;
    set_issue(4'd3, 5'd5, 7'h0B, 32'hF0, 32'h7);
    #1;
    chk("t1_accept", 32'(issue_accept_o), 32'd1);
    chk("t1_writeback", 32'(issue_writeback_o), 32'd1);
    step();
    set_commit(4'd3, 1'b0);
    step();
    wait_result(20);
    chk("t1_starts", 32'(start_cnt), 32'd1);
    chk("t1_id", 32'(result_id_o), 32'd3);
    chk("t1_rd", 32'(result_rd_o), 32'd5);
    chk("t1_data", result_data_o, 32'h4);
    // Back-pressure on the result for five cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_hold_valid", 32'(result_valid_o), 32'd1);
      chk("t1_hold_data", result_data_o, 32'h4);
    end
    chk("t1_no_restart", 32'(start_cnt), 32'd1);
    take_result();
    chk("t1_released", 32'(result_valid_o), 32'd0);

    // Foreign opcode is neither accepted nor queued
    start_cnt = 0;
    set_issue(4'd4, 5'd2, 7'h33, 32'h1, 32'h2);
    #1;
    chk("t2_accept", 32'(issue_accept_o), 32'd0);
    chk("t2_writeback", 32'(issue_writeback_o), 32'd0);
    repeat (5) step();
    chk("t2_no_start", 32'(start_cnt), 32'd0);
    chk("t2_ready", 32'(issue_ready_o), 32'd1);

    // Fill the queue, kill the first, execute the second
    start_cnt = 0;
    done_val = 32'hABCD;
    set_issue(4'd1, 5'd1, 7'h0B, 32'h111, 32'h1111);
    step();
    set_issue(4'd2, 5'd2, 7'h0B, 32'h222, 32'h2222);
    step();
    chk("t3_full", 32'(issue_ready_o), 32'd0);
    set_commit(4'd1, 1'b1);
    step();
    set_commit(4'd2, 1'b0);
    step();
    wait_result(20);
    chk("t3_starts", 32'(start_cnt), 32'd1);
    chk("t3_rs0", ex_rs0_o, 32'h222);
    chk("t3_id", 32'(result_id_o), 32'd2);
    chk("t3_data", result_data_o, 32'hABCD);
    take_result();
    chk("t3_ready", 32'(issue_ready_o), 32'd1);

    // Commit in the same cycle as the issue of its ID
    start_cnt = 0;
    done_val = 32'h66;
    set_issue(4'd6, 5'd6, 7'h0B, 32'h6, 32'h60);
    set_commit(4'd6, 1'b0);
    step();
    wait_result(20);
    chk("t4_starts", 32'(start_cnt), 32'd1);
    chk("t4_id", 32'(result_id_o), 32'd6);
    take_result();

    // Asynchronous reset while executing
    done_lat = 3;
    set_issue(4'd9, 5'd9, 7'h0B, 32'h99, 32'h990);
    set_commit(4'd9, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      if (ex_start_o) break;
      step();
    end
    chk("t5_started", 32'(ex_start_o), 32'd1);
    step();
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(issue_ready_o), 32'd1);
    chk("t5_rst_start", 32'(ex_start_o), 32'd0);
    chk("t5_rst_rvalid", 32'(result_valid_o), 32'd0);
    chk("t5_rst_rs0", ex_rs0_o, 32'd0);
    chk("t5_rst_rs1", ex_rs1_o, 32'd0);
    chk("t5_rst_rdata", result_data_o, 32'd0);
    @(posedge clk_i);
    #2;
    dp_busy = 1'b0;
    ex_done_i = 1'b0;
    rst_ni = 1'b1;
    start_cnt = 0;
    repeat (5) step();
    chk("t5_empty_ready", 32'(issue_ready_o), 32'd1);
    chk("t5_no_start", 32'(start_cnt), 32'd0);

    // Randomized traffic
    rand_dp = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      op = ($urandom_range(99) < 75) ? 7'h0B : 7'($urandom);
      set_issue(4'($urandom_range(7)), 5'($urandom), op, $urandom, $urandom);
      issue_valid_i = ($urandom_range(99) < 50);
      if ($urandom_range(99) < 40) begin
        if (mq.size() > 0 && $urandom_range(99) < 80)
          set_commit(mq[$urandom_range(mq.size() - 1)].id, ($urandom_range(99) < 25));
        else
          set_commit(4'($urandom_range(7)), ($urandom_range(99) < 25));
      end
      result_ready_i = ($urandom_range(99) < 60);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
